// File: rtl/link_pkg.sv
// Shared types and helpers for the serial link transceiver.
package link_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_SHIFT    = 2'd1,
        RX_WAIT_GAP = 2'd2
    } rx_state_t;

    function automatic int unsigned frame_w(input int unsigned data_w, input bit parity_en);
        return data_w + 32'(parity_en);
    endfunction

    // Even parity over up to 16 data bits (zero-extended).
    function automatic logic even_parity(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// Synchronous show-ahead FIFO; a pop frees space for a same-cycle push when full.
module link_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/serial_link_transceiver.sv
// Serial word link: framed TX with one pending slot, RX with parity/framing checks
// feeding a show-ahead FIFO, plus the legacy per-word toggle towards the PIO.
module serial_link_transceiver
    import link_pkg::*;
#(
    parameter int unsigned DATA_W        = 4,
    parameter bit          PARITY_EN     = 1'b1,
    parameter int unsigned RX_DEPTH      = 4,
    parameter bit          SUBMIT_TOGGLE = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             tx_word,
    input  logic                          tx_submit,
    output logic                          tx_busy,
    output logic                          tx_drop,
    output logic                          TX_data,
    output logic                          TX_ready,
    input  logic                          RX_data,
    input  logic                          RX_ready,
    input  logic                          rx_enable,
    output logic [DATA_W-1:0]             rx_word,
    output logic                          rx_valid,
    input  logic                          rx_pop,
    output logic                          rx_toggle,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_count,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_overflow
);

    localparam int unsigned FRAME_W = frame_w(DATA_W, PARITY_EN);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] w);
        if (PARITY_EN) return FRAME_W'({w, even_parity(16'(w))});
        else           return FRAME_W'(w);
    endfunction

    // ---------------- transmitter ----------------
    tx_state_t          tx_state, tx_next;
    logic [FRAME_W-1:0] tx_shift;
    logic [CNT_W-1:0]   tx_cnt;
    logic [DATA_W-1:0]  pend_word;
    logic               pend_full;
    logic               submit_hist;
    logic               submit_evt;
    logic               tx_last;
    logic               tx_load;
    logic [DATA_W-1:0]  tx_src;

    assign submit_evt = SUBMIT_TOGGLE ? (tx_submit ^ submit_hist) : tx_submit;
    assign tx_last    = (tx_cnt == CNT_W'(FRAME_W - 1));
    assign tx_load    = ((tx_state == TX_IDLE) && submit_evt) ||
                        ((tx_state == TX_GAP) && (pend_full || submit_evt));
    assign tx_src     = ((tx_state == TX_GAP) && pend_full) ? pend_word : tx_word;
    assign tx_busy    = (tx_state != TX_IDLE) | pend_full;

    always_ff @(posedge clock) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (submit_evt) tx_next = TX_SEND;
            TX_SEND: if (tx_last) tx_next = TX_GAP;
            TX_GAP:  tx_next = (pend_full || submit_evt) ? TX_SEND : TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        TX_ready = (tx_state == TX_SEND);
        TX_data  = (tx_state == TX_SEND) & tx_shift[FRAME_W-1];
    end

    always_ff @(posedge clock) begin
        submit_hist <= tx_submit;
        if (reset) begin
            tx_shift  <= '0;
            tx_cnt    <= '0;
            pend_word <= '0;
            pend_full <= 1'b0;
            tx_drop   <= 1'b0;
        end else begin
            tx_drop <= 1'b0;
            if (tx_load) begin
                tx_shift <= build_frame(tx_src);
                tx_cnt   <= '0;
            end else if (tx_state == TX_SEND) begin
                tx_shift <= tx_shift << 1;
                tx_cnt   <= tx_last ? '0 : tx_cnt + CNT_W'(1);
            end
            if ((tx_state == TX_GAP) && pend_full) pend_full <= 1'b0;
            // An empty slot during GAP is bypassed: the word loads straight into the shifter.
            if (submit_evt && (tx_state != TX_IDLE)) begin
                if (pend_full) begin
                    tx_drop <= 1'b1;
                end else if (tx_state == TX_SEND) begin
                    pend_full <= 1'b1;
                    pend_word <= tx_word;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t          rx_state, rx_next;
    logic [FRAME_W-1:0] rx_shift;
    logic [FRAME_W-1:0] rx_frame;
    logic [DATA_W-1:0]  rx_payload;
    logic [CNT_W-1:0]   rx_cnt;
    logic               rx_done;
    logic               cap;
    logic               parity_ok;
    logic               gap_violation;
    logic               rx_complete;
    logic               frame_err_c;
    logic               push_c;
    logic               push_ok;
    logic               fifo_full;
    logic               fifo_empty;

    assign cap        = rx_enable & RX_ready;
    assign rx_frame   = FRAME_W'({rx_shift, RX_data});
    assign rx_payload = rx_frame[FRAME_W-1 -: DATA_W];
    assign parity_ok  = !PARITY_EN || (even_parity(16'(rx_payload)) == rx_frame[0]);
    assign push_ok    = push_c & (~fifo_full | rx_pop);

    always_ff @(posedge clock) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (gap_violation)           rx_next = RX_WAIT_GAP;
                else if (cap && !rx_complete) rx_next = RX_SHIFT;
            end
            RX_SHIFT:    if (!rx_enable || !RX_ready || rx_complete) rx_next = RX_IDLE;
            RX_WAIT_GAP: if (!RX_ready) rx_next = RX_IDLE;
            default:     rx_next = RX_IDLE;
        endcase
    end

    // rx_done marks the cycle right after a completed frame, when RX_ready must be low.
    always_comb begin
        gap_violation = (rx_state == RX_IDLE) && rx_done && RX_ready;
        rx_complete   = cap && (rx_cnt == CNT_W'(FRAME_W - 1)) &&
                        ((rx_state == RX_SHIFT) || ((rx_state == RX_IDLE) && !gap_violation));
        frame_err_c   = gap_violation || ((rx_state == RX_SHIFT) && rx_enable && !RX_ready);
        push_c        = rx_complete && parity_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_shift      <= '0;
            rx_cnt        <= '0;
            rx_done       <= 1'b0;
            rx_toggle     <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overflow   <= 1'b0;
        end else begin
            rx_done       <= rx_complete;
            rx_parity_err <= rx_complete & ~parity_ok;
            rx_frame_err  <= frame_err_c;
            rx_overflow   <= push_c & ~push_ok;
            if (push_ok) rx_toggle <= ~rx_toggle;
            if (rx_next != RX_SHIFT) begin
                rx_cnt <= '0;
            end else if (cap) begin
                rx_shift <= rx_frame;
                rx_cnt   <= rx_cnt + CNT_W'(1);
            end
        end
    end

    link_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_c),
        .wdata (rx_payload),
        .pop   (rx_pop),
        .rdata (rx_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (rx_count)
    );

    assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_serial_link_transceiver.sv
// Scoreboard bench for serial_link_transceiver: loopback and injected RX frames,
// with TX frames and popped RX words checked by independent monitors.
module tb_serial_link_transceiver;

    localparam int unsigned FRAME_W = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] tx_word;
    logic       tx_submit;
    logic       tx_busy, tx_drop, TX_data, TX_ready;
    logic       RX_data, RX_ready, rx_enable;
    logic [3:0] rx_word;
    logic       rx_valid, rx_pop, rx_toggle;
    logic [2:0] rx_count;
    logic       rx_parity_err, rx_frame_err, rx_overflow;

    logic loop, inj_data, inj_ready, auto_pop, man_pop;
    logic mon_pop = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_drop = 0, n_par = 0, n_ferr = 0, n_ovf = 0, n_tog = 0;
    logic prev_tog = 1'b0;

    logic [3:0] exp_rx[$];
    logic [4:0] exp_tx[$];

    logic [4:0] tx_bits  = '0;
    int         tx_nb    = 0;
    int         idle_run = 0;
    int         last_gap = -1;

    always #5 clock = ~clock;

    assign RX_data  = loop ? TX_data  : inj_data;
    assign RX_ready = loop ? TX_ready : inj_ready;
    assign rx_pop   = mon_pop | man_pop;

    serial_link_transceiver #(
        .DATA_W(4), .PARITY_EN(1'b1), .RX_DEPTH(4), .SUBMIT_TOGGLE(1'b1)
    ) dut (
        .clock(clock), .reset(reset),
        .tx_word(tx_word), .tx_submit(tx_submit), .tx_busy(tx_busy), .tx_drop(tx_drop),
        .TX_data(TX_data), .TX_ready(TX_ready),
        .RX_data(RX_data), .RX_ready(RX_ready), .rx_enable(rx_enable),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_pop(rx_pop), .rx_toggle(rx_toggle),
        .rx_count(rx_count), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_overflow(rx_overflow)
    );

    function automatic logic [4:0] mk_frame(input logic [3:0] w);
        return {w, w[3] ^ w[2] ^ w[1] ^ w[0]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // TX monitor: assemble frames on TX_ready, compare whole frames, track gap length.
    always @(negedge clock) begin
        if (reset) begin
            tx_nb    = 0;
            idle_run = 0;
        end else if (TX_ready) begin
            if (tx_nb == 0) begin
                last_gap = idle_run;
                idle_run = 0;
            end
            tx_bits = {tx_bits[3:0], TX_data};
            tx_nb++;
            if (tx_nb == FRAME_W) begin
                tx_nb = 0;
                if (exp_tx.size() == 0) check("tx_unexpected_frame", int'(tx_bits), -1);
                else                    check("tx_frame", int'(tx_bits), int'(exp_tx.pop_front()));
            end
        end else begin
            idle_run++;
            tx_nb = 0;
        end
    end

    // RX monitor: every word consumed from the FIFO is compared against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            mon_pop = 1'b0;
        end else begin
            if (rx_valid && (auto_pop || man_pop)) begin
                if (exp_rx.size() == 0) check("rx_unexpected_word", int'(rx_word), -1);
                else                    check("rx_word", int'(rx_word), int'(exp_rx.pop_front()));
            end
            mon_pop = auto_pop && rx_valid;
        end
    end

    // Pulse and toggle counters.
    always @(negedge clock) begin
        if (!reset) begin
            n_drop += int'(tx_drop);
            n_par  += int'(rx_parity_err);
            n_ferr += int'(rx_frame_err);
            n_ovf  += int'(rx_overflow);
            if (rx_toggle != prev_tog) n_tog++;
        end
        prev_tog = rx_toggle;
    end

    task automatic submit(input logic [3:0] w, input bit expect_it);
        tx_word   = w;
        tx_submit = ~tx_submit;
        if (expect_it) begin
            exp_tx.push_back(mk_frame(w));
            if (loop) exp_rx.push_back(w);
        end
        tick(1);
    endtask

    task automatic inject(input logic [15:0] bits, input int n, input bit pop_last);
        for (int i = n - 1; i >= 0; i--) begin
            inj_ready = 1'b1;
            inj_data  = bits[i];
            if (i == 0 && pop_last) man_pop = 1'b1;
            tick(1);
            man_pop = 1'b0;
        end
        inj_ready = 1'b0;
        inj_data  = 1'b0;
        tick(2);
    endtask

    task automatic inject_word(input logic [3:0] w, input bit expect_it, input bit pop_last);
        if (expect_it) exp_rx.push_back(w);
        inject({11'd0, mk_frame(w)}, 5, pop_last);
    endtask

    initial begin
        reset = 1'b1; tx_submit = 1'b1; tx_word = 4'h0; rx_enable = 1'b1;
        loop = 1'b1; inj_data = 1'b0; inj_ready = 1'b0; auto_pop = 1'b0; man_pop = 1'b0;
        tick(3);
        check("reset_TX_ready", int'(TX_ready), 0);
        check("reset_TX_data", int'(TX_data), 0);
        check("reset_tx_busy", int'(tx_busy), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_count", int'(rx_count), 0);
        check("reset_rx_toggle", int'(rx_toggle), 0);
        reset = 1'b0;
        tick(2);
        check("no_event_from_reset", int'(tx_busy), 0);

        // Loopback of 4'hB: frame 1,0,1,1,1.
        submit(4'hB, 1'b1);
        tick(8);
        check("loop_rx_valid", int'(rx_valid), 1);
        check("loop_rx_count", int'(rx_count), 1);
        check("loop_toggle", n_tog, 1);
        auto_pop = 1'b1;
        tick(3);
        check("loop_rx_drained", exp_rx.size(), 0);

        // Back-to-back: 3 sent, 5 pended, 6 dropped.
        submit(4'h3, 1'b1);
        submit(4'h5, 1'b1);
        submit(4'h6, 1'b0);
        tick(18);
        check("b2b_drop", n_drop, 1);
        check("b2b_gap", last_gap, 1);
        check("b2b_tx_done", exp_tx.size(), 0);
        check("b2b_rx_done", exp_rx.size(), 0);
        check("b2b_idle", int'(tx_busy), 0);

        // Parity error: data 0110 with parity bit 1.
        loop = 1'b0;
        inject(16'b01101, 5, 1'b0);
        check("parity_err", n_par, 1);
        check("parity_count", int'(rx_count), 0);

        // Truncated frame after 2 bits.
        inject(16'b10, 2, 1'b0);
        check("trunc_frame_err", n_ferr, 1);
        check("trunc_count", int'(rx_count), 0);

        // RX_ready held 7 cycles: good 4'hA then one framing error.
        exp_rx.push_back(4'hA);
        inject(16'b1010011, 7, 1'b0);
        tick(2);
        check("long_frame_err", n_ferr, 2);
        check("long_word_seen", exp_rx.size(), 0);

        // Fill FIFO, overflow, then push with pop on the same edge.
        auto_pop = 1'b0;
        for (int i = 1; i <= 4; i++) inject_word(4'(i), 1'b1, 1'b0);
        check("fill_count", int'(rx_count), 4);
        inject_word(4'h7, 1'b0, 1'b0);
        check("overflow", n_ovf, 1);
        check("overflow_count", int'(rx_count), 4);
        inject_word(4'h8, 1'b1, 1'b1);
        check("pushpop_no_overflow", n_ovf, 1);
        check("pushpop_count", int'(rx_count), 4);
        check("pushpop_toggles", n_tog, 9);
        auto_pop = 1'b1;
        for (int i = 0; i < 30 && (exp_rx.size() != 0 || rx_valid); i++) tick(1);
        check("drain_count", int'(rx_count), 0);
        check("drain_scoreboard", exp_rx.size(), 0);

        // rx_enable dropped mid-frame: silent abort, next frame clean.
        inj_ready = 1'b1; inj_data = 1'b1; tick(1);
        inj_data = 1'b0; tick(1);
        rx_enable = 1'b0; inj_data = 1'b1; tick(1);
        inj_ready = 1'b0; tick(1);
        rx_enable = 1'b1; tick(1);
        check("abort_no_err", n_ferr, 2);
        inject_word(4'h5, 1'b1, 1'b0);
        tick(2);
        check("abort_next_word", exp_rx.size(), 0);
        check("abort_no_parity", n_par, 1);

        // Reset mid-frame in loopback.
        loop = 1'b1;
        submit(4'hF, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midreset_TX_ready", int'(TX_ready), 0);
        check("midreset_busy", int'(tx_busy), 0);
        reset = 1'b0;
        tick(3);
        check("postreset_quiet", int'(TX_ready), 0);
        check("postreset_count", int'(rx_count), 0);
        check("final_tx_scoreboard", exp_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
